// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;

  localparam int unsigned PC_W_DEF  = 8;
  localparam int unsigned IR_W_DEF  = 16;
  localparam int unsigned CTL_W_DEF = 8;

  localparam logic [IR_W_DEF-1:0] NOP_IR = '0;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at Max instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 8,
  parameter int unsigned Max   = (1 << Width) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [Width-1:0] count
);

  localparam logic [Width-1:0] MaxVal = Width'(Max);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != MaxVal)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// IF/DOF and DOF/EX pipeline registers with data-hazard stall, branch flush and stall statistics.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned IR_W      = IR_W_DEF,
  parameter int unsigned CTL_W     = CTL_W_DEF,
  parameter int unsigned STALL_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dhs,
  input  logic             flush,
  input  logic [PC_W-1:0]  pc_in,
  input  logic [IR_W-1:0]  ir_in,
  input  logic [2:0]       da_in,
  input  logic             rw_in,
  input  logic             mw_in,
  input  logic [CTL_W-1:0] ctl_in,
  output logic             pc_en,
  output logic [PC_W-1:0]  pc_out,
  output logic [IR_W-1:0]  ir_out,
  output logic [2:0]       da_ex,
  output logic             rw_ex,
  output logic             mw_ex,
  output logic [CTL_W-1:0] ctl_ex,
  output logic [1:0]       state,
  output logic [7:0]       stall_cnt,
  output logic             stall_err
);

  localparam int unsigned RunW = $clog2(STALL_MAX + 1);

  logic             advance;
  logic             stall_cyc;
  logic [PC_W-1:0]  pc_q;
  logic [IR_W-1:0]  ir_q;
  logic [2:0]       da_q;
  logic             rw_q;
  logic             mw_q;
  logic [CTL_W-1:0] ctl_q;
  logic [RunW-1:0]  run_cnt;
  logic             err_q;
  pipe_state_e      state_q, state_d;

  // Flush wins over a hazard stall: the stalled instruction is squashed, not held.
  assign advance   = dhs & ~flush;
  assign stall_cyc = ~dhs & ~flush;
  assign pc_en     = dhs | flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      ir_q  <= '0;
      da_q  <= '0;
      rw_q  <= 1'b0;
      mw_q  <= 1'b0;
      ctl_q <= '0;
    end else begin
      if (flush) begin
        pc_q <= pc_in;
        ir_q <= IR_W'(NOP_IR);
      end else if (dhs) begin
        pc_q <= pc_in;
        ir_q <= ir_in;
      end
      if (advance) begin
        da_q  <= da_in;
        rw_q  <= rw_in;
        mw_q  <= mw_in;
        ctl_q <= ctl_in;
      end else begin
        da_q  <= '0;
        rw_q  <= 1'b0;
        mw_q  <= 1'b0;
        ctl_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StRun;
    if (flush) begin
      state_d = StFlush;
    end else begin
      unique case (state_q)
        StRun, StStall: state_d = dhs ? StRun : StStall;
        StFlush:        state_d = StRun;
        default:        state_d = StRun;
      endcase
    end
  end

  always_comb begin
    state = state_q;
  end

  sat_counter #(
    .Width(8)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_cyc),
    .clr  (1'b0),
    .count(stall_cnt)
  );

  sat_counter #(
    .Width(RunW),
    .Max  (STALL_MAX)
  ) u_run_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_cyc),
    .clr  (~stall_cyc),
    .count(run_cnt)
  );

  // Set on the edge where the consecutive-stall run reaches STALL_MAX.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (stall_cyc && (run_cnt >= RunW'(STALL_MAX - 1))) begin
      err_q <= 1'b1;
    end
  end

  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign da_ex     = da_q;
  assign rw_ex     = rw_q;
  assign mw_ex     = mw_q;
  assign ctl_ex    = ctl_q;
  assign stall_err = err_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench: stimulus queues expected outputs, a negedge monitor checks them.
module tb_pipe_stall_ctrl;

  typedef struct packed {
    logic        rst;
    logic        dhs;
    logic        flush;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [2:0]  da;
    logic        rw;
    logic        mw;
    logic [7:0]  ctl;
  } in_t;

  typedef struct packed {
    logic        pc_en;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [2:0]  da;
    logic        rw;
    logic        mw;
    logic [7:0]  ctl;
    logic [1:0]  st;
    logic [7:0]  cnt;
    logic        err;
  } want_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dhs = 1'b1;
  logic        flush = 1'b0;
  logic [7:0]  pc_in = '0;
  logic [15:0] ir_in = '0;
  logic [2:0]  da_in = '0;
  logic        rw_in = 1'b0;
  logic        mw_in = 1'b0;
  logic [7:0]  ctl_in = '0;
  logic        pc_en;
  logic [7:0]  pc_out;
  logic [15:0] ir_out;
  logic [2:0]  da_ex;
  logic        rw_ex;
  logic        mw_ex;
  logic [7:0]  ctl_ex;
  logic [1:0]  state;
  logic [7:0]  stall_cnt;
  logic        stall_err;

  int    n_tests = 0;
  int    n_fail  = 0;
  want_t sb[$];

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .dhs      (dhs),
    .flush    (flush),
    .pc_in    (pc_in),
    .ir_in    (ir_in),
    .da_in    (da_in),
    .rw_in    (rw_in),
    .mw_in    (mw_in),
    .ctl_in   (ctl_in),
    .pc_en    (pc_en),
    .pc_out   (pc_out),
    .ir_out   (ir_out),
    .da_ex    (da_ex),
    .rw_ex    (rw_ex),
    .mw_ex    (mw_ex),
    .ctl_ex   (ctl_ex),
    .state    (state),
    .stall_cnt(stall_cnt),
    .stall_err(stall_err)
  );

  function automatic in_t vi(input logic r, input logic d, input logic f, input logic [7:0] pc,
                             input logic [15:0] ir, input logic [2:0] da, input logic rw,
                             input logic mw, input logic [7:0] ctl);
    vi = '{rst: r, dhs: d, flush: f, pc: pc, ir: ir, da: da, rw: rw, mw: mw, ctl: ctl};
  endfunction

  function automatic want_t ve(input logic en, input logic [7:0] pc, input logic [15:0] ir,
                               input logic [2:0] da, input logic rw, input logic mw,
                               input logic [7:0] ctl, input logic [1:0] st,
                               input logic [7:0] cnt, input logic err);
    ve = '{pc_en: en, pc: pc, ir: ir, da: da, rw: rw, mw: mw, ctl: ctl, st: st, cnt: cnt,
           err: err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  // Inputs change 1 time unit after negedge; the registered response is checked one cycle later.
  task automatic step(input in_t i, input want_t w);
    @(negedge clk);
    #1;
    rst    = i.rst;
    dhs    = i.dhs;
    flush  = i.flush;
    pc_in  = i.pc;
    ir_in  = i.ir;
    da_in  = i.da;
    rw_in  = i.rw;
    mw_in  = i.mw;
    ctl_in = i.ctl;
    sb.push_back(w);
  endtask

  initial begin : monitor
    want_t w;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("pc_en", 32'(pc_en), 32'(w.pc_en));
        chk("pc_out", 32'(pc_out), 32'(w.pc));
        chk("ir_out", 32'(ir_out), 32'(w.ir));
        chk("da_ex", 32'(da_ex), 32'(w.da));
        chk("rw_ex", 32'(rw_ex), 32'(w.rw));
        chk("mw_ex", 32'(mw_ex), 32'(w.mw));
        chk("ctl_ex", 32'(ctl_ex), 32'(w.ctl));
        chk("state", 32'(state), 32'(w.st));
        chk("stall_cnt", 32'(stall_cnt), 32'(w.cnt));
        chk("stall_err", 32'(stall_err), 32'(w.err));
      end
    end
  end

  initial begin : stimulus
    int cnt;
    int waited;
    // Reset with live inputs: everything clears, pc_en still follows dhs | flush.
    step(vi(1, 1, 0, 8'h10, 16'hAAAA, 3'd5, 1, 1, 8'hFF), ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Normal advance.
    step(vi(0, 1, 0, 8'h01, 16'h1234, 3'd3, 1, 0, 8'h5A),
         ve(1, 8'h01, 16'h1234, 3'd3, 1, 0, 8'h5A, 0, 0, 0));
    // Three stalls: hold IF/DOF, bubble EX, error on the third.
    step(vi(0, 0, 0, 8'h02, 16'h5678, 3'd7, 1, 1, 8'h11),
         ve(0, 8'h01, 16'h1234, 0, 0, 0, 0, 1, 1, 0));
    step(vi(0, 0, 0, 8'h03, 16'h9ABC, 3'd7, 1, 1, 8'h11),
         ve(0, 8'h01, 16'h1234, 0, 0, 0, 0, 1, 2, 0));
    step(vi(0, 0, 0, 8'h03, 16'hDEF0, 3'd7, 1, 1, 8'h11),
         ve(0, 8'h01, 16'h1234, 0, 0, 0, 0, 1, 3, 1));
    step(vi(0, 1, 0, 8'h04, 16'h4321, 3'd2, 0, 1, 8'h33),
         ve(1, 8'h04, 16'h4321, 3'd2, 0, 1, 8'h33, 0, 3, 1));
    // Flush beats stall; flush held keeps FLUSH; release returns to RUN.
    step(vi(0, 0, 1, 8'h05, 16'h7777, 3'd1, 1, 1, 8'h01),
         ve(1, 8'h05, 16'h0000, 0, 0, 0, 0, 2, 3, 1));
    step(vi(0, 1, 1, 8'h06, 16'h8888, 3'd1, 1, 1, 8'h01),
         ve(1, 8'h06, 16'h0000, 0, 0, 0, 0, 2, 3, 1));
    step(vi(0, 1, 0, 8'h07, 16'h1111, 3'd4, 1, 0, 8'h44),
         ve(1, 8'h07, 16'h1111, 3'd4, 1, 0, 8'h44, 0, 3, 1));
    // Reset clears the sticky error.
    step(vi(1, 0, 0, 8'h20, 16'h2020, 3'd6, 1, 1, 8'h22), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Two stalls, one advance, then a long stall: the run counter must restart.
    step(vi(0, 0, 0, 8'h21, 16'h2121, 3'd6, 1, 1, 8'h22), ve(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step(vi(0, 0, 0, 8'h22, 16'h2222, 3'd6, 1, 1, 8'h22), ve(0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    step(vi(0, 1, 0, 8'h08, 16'h2222, 3'd6, 0, 0, 8'h00),
         ve(1, 8'h08, 16'h2222, 3'd6, 0, 0, 8'h00, 0, 2, 0));
    for (int i = 1; i <= 300; i++) begin
      cnt = (2 + i > 255) ? 255 : 2 + i;
      step(vi(0, 0, 0, 8'h30, 16'(i), 3'd7, 1, 1, 8'hFF),
           ve(0, 8'h08, 16'h2222, 0, 0, 0, 0, 1, 8'(cnt), (i >= 3)));
    end
    // Reset mid-stall discards the held instruction.
    step(vi(1, 0, 0, 8'h31, 16'h3131, 3'd7, 1, 1, 8'hFF), ve(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step(vi(0, 1, 0, 8'h09, 16'hABCD, 3'd5, 1, 1, 8'h77),
         ve(1, 8'h09, 16'hABCD, 3'd5, 1, 1, 8'h77, 0, 0, 0));
    step(vi(0, 0, 0, 8'h0A, 16'h1111, 3'd1, 1, 1, 8'h01),
         ve(0, 8'h09, 16'hABCD, 0, 0, 0, 0, 1, 1, 0));
    // Flush out of STALL, then a stall straight out of FLUSH goes to RUN but still counts.
    step(vi(0, 1, 1, 8'h0B, 16'h2222, 3'd2, 1, 1, 8'h01),
         ve(1, 8'h0B, 16'h0000, 0, 0, 0, 0, 2, 1, 0));
    step(vi(0, 0, 0, 8'h0C, 16'h3333, 3'd2, 1, 1, 8'h01),
         ve(0, 8'h0B, 16'h0000, 0, 0, 0, 0, 0, 2, 0));
    step(vi(0, 0, 0, 8'h0D, 16'h3333, 3'd2, 1, 1, 8'h01),
         ve(0, 8'h0B, 16'h0000, 0, 0, 0, 0, 1, 3, 0));
    step(vi(0, 1, 0, 8'h0E, 16'h4444, 3'd3, 0, 0, 8'h00),
         ve(1, 8'h0E, 16'h4444, 3'd3, 0, 0, 8'h00, 0, 3, 0));
    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
